// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Run-time controller for a programmable integer clock divider.
//               New divide ratios arrive over a valid/ready config port and
//               are applied only at output-period boundaries, so clk_out never
//               glitches or produces a runt pulse. The divided output starts
//               one edge after run_req rises and stops cleanly at the end of
//               the period in which run_req falls.
// Parameters  : CNT_W       - width of divide ratio and period counter
//               DEFAULT_DIV - active ratio after reset (>= MIN_DIV)
//               MIN_DIV     - smallest legal ratio; smaller requests rejected
// Ports       : clk_in     - sole clock (rising edge)
//               rst        - synchronous active-high reset
//               cfg_valid  - config request valid
//               cfg_div    - requested divide ratio
//               cfg_ready  - high when no accepted ratio is pending
//               cfg_err    - 1-cycle pulse after a rejected (too small) ratio
//               run_req    - level: 1 = run, 0 = stop at period end
//               running    - high while not idle
//               active_div - ratio currently in use
//               clk_out    - registered divided clock
//               tick       - (CLKDIV_CTRL_TICK_EN only) 1-cycle pulse in the
//                            cycle clk_out rises; a clk_in-domain enable
// Options     : `define CLKDIV_CTRL_TICK_EN to add the tick output.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int MIN_DIV     = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    input  logic             run_req,
    output logic             running,
    output logic [CNT_W-1:0] active_div,
    output logic             clk_out
`ifdef CLKDIV_CTRL_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_STOPPING = 2'd2;

    localparam logic [CNT_W-1:0] c_MIN_DIV     = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_active_div;
    logic             r_pend_vld;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_err;
    logic             r_clk_out;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_clk_nxt;
    logic             w_wrap;
    logic             w_apply;
    logic             w_xfer;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_high_len;

    // A pending ratio blocks further transfers, so transfer and apply can
    // never land on the same edge.
    assign w_xfer  = cfg_valid && !r_pend_vld;
    assign w_wrap  = (r_cnt == (r_active_div - c_ONE));
    assign w_apply = r_pend_vld && ((r_state == c_IDLE) || w_wrap);

    // The high-phase length is taken from the ratio that will be active after
    // this edge, so a freshly applied ratio shapes its very first period.
    assign w_div_nxt  = w_apply ? r_pend_div : r_active_div;
    assign w_high_len = w_div_nxt - (w_div_nxt >> 1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clk_nxt   = r_clk_out;
        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                w_clk_nxt = 1'b0;
                if (run_req) begin
                    w_state_nxt = c_RUN;
                    w_clk_nxt   = 1'b1;
                end
            end
            c_RUN, c_STOPPING: begin
                w_cnt_nxt = w_wrap ? '0 : (r_cnt + c_ONE);
                w_clk_nxt = (w_cnt_nxt < w_high_len);
                if (r_state == c_RUN) begin
                    if (!run_req) begin
                        w_state_nxt = c_STOPPING;
                    end
                end else if (run_req) begin
                    // Resume without touching the count: no gap, no phase jump.
                    w_state_nxt = c_RUN;
                end else if (w_wrap) begin
                    // Period complete: stop instead of starting a new high phase.
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                    w_clk_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_clk_out    <= 1'b0;
            r_active_div <= c_DEFAULT_DIV;
            r_pend_vld   <= 1'b0;
            r_pend_div   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= w_clk_nxt;
            r_err     <= w_xfer && (cfg_div < c_MIN_DIV);
            if (w_apply) begin
                r_active_div <= r_pend_div;
            end
            if (w_xfer && (cfg_div >= c_MIN_DIV)) begin
                r_pend_vld <= 1'b1;
                r_pend_div <= cfg_div;
            end else if (w_apply) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_CTRL_TICK_EN
    logic r_tick;

    // Every period starts at count zero with clk_out going high, so a zero
    // next count in an active state marks exactly the rising edges.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= (w_state_nxt != c_IDLE) && (w_cnt_nxt == '0);
        end
    end

    assign tick = r_tick;
`endif

    assign cfg_ready  = !r_pend_vld;
    assign cfg_err    = r_err;
    assign running    = (r_state != c_IDLE);
    assign active_div = r_active_div;
    assign clk_out    = r_clk_out;

endmodule
`default_nettype wire
